ula_nibble_seq: RTL and testbench
=================================

Name: ula_nibble_seq

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational ALU slice.
- Operates on WIDTH-bit operands by reusing one 4-bit function slice, one nibble per clock, LSB nibble first, with the carry chained between cycles.
- Uses valid/ready handshakes on input and output, so a datapath controller can issue operations and collect results with flags.

Parameters:
- WIDTH, 16, operand width; must be a multiple of 4 and at least 4. N = WIDTH/4 nibble cycles.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- s  in  4  function select {S3,S2,S1,S0}
- m  in  1  1 = logic mode, 0 = arithmetic mode
- c_in  in  1  carry-in into nibble 0
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- f  out  WIDTH  result
- c_out  out  1  carry out of bit WIDTH-1 (0 in logic mode)
- a_eq_b  out  1  latched A == B, full width
- zero  out  1  f == 0

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=1 after reset release. out_valid=0, f=0, c_out=0, a_eq_b=0, zero=0, internal operands and nibble index cleared. Reset mid-RUN or mid-DONE aborts the operation and loses the result.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. A transfer on in_valid&&in_ready latches a, b, s, m, c_in, sets carry=c_in and k=0, then goes to RUN.
- RUN: in_ready=0. Each cycle processes nibble k with the current carry, writes f[4k+3:4k], updates carry, and increments k. After nibble N-1, goes to DONE. Inputs a, b, s, m and c_in are ignored while in RUN.
- DONE: out_valid=1. f, c_out, a_eq_b and zero stay stable until out_ready=1. On out_valid&&out_ready, goes to IDLE and out_valid drops in the next cycle.
- If out_ready is held high, no results are lost or duplicated.
- Latency: the accept edge plus N RUN cycles, so out_valid rises N+1 edges after the accept edge (5 for WIDTH=16). Back-to-back throughput is one operation per N+2 cycles. in_ready is never high while out_valid is high.
- Logic mode (m=1), per bit:
  - 0000 ~A, 0001 ~(A|B), 0010 ~A&B, 0011 0
  - 0100 ~(A&B), 0101 ~B, 0110 A^B, 0111 A&~B
  - 1000 A&B, 1001 ~(A^B), 1010 B, 1011 ~A|B
  - 1100 all-ones, 1101 A|~B, 1110 A|B, 1111 A
  - Carry is forced to 0 and c_out=0.
- Arithmetic mode (m=0): f = (X + Y + c_in) mod 2^WIDTH and c_out = bit WIDTH of that sum. "-1" means Y is all-ones.
  - 0000 X=A,Y=0; 0001 X=A|B,Y=0; 0010 X=A|~B,Y=0; 0011 X=0,Y=-1
  - 0100 X=A,Y=A&~B; 0101 X=A|B,Y=A&~B; 0110 X=A,Y=~B; 0111 X=A&~B,Y=-1
  - 1000 X=A,Y=A&B; 1001 X=A,Y=B; 1010 X=A|~B,Y=A&B; 1011 X=A&B,Y=-1
  - 1100 X=A,Y=A; 1101 X=A|B,Y=A; 1110 X=A|~B,Y=A; 1111 X=A,Y=-1
  - Nibble-serial chaining must produce results identical to the full-width sum.
- Flags: a_eq_b is computed from the latched operands, independent of mode. zero reflects the final f. Both are updated on entry to DONE.

Optional Feature:
- Macro: ULA_OVF_EN.
- Defined: adds output ovf (1 bit, reset 0), updated on entry to DONE. In arithmetic mode, ovf = (X[W-1]==Y[W-1]) && (f[W-1]!=X[W-1]), i.e. two's-complement overflow of X+Y+c_in. In logic mode, ovf=0.
- Undefined: the port and its logic are absent. All other behaviour is unchanged.

Test Plan (WIDTH=16):
- m=0, s=1001, a=0x00FF, b=0x0001, c_in=0 -> f=0x0100, c_out=0, zero=0, out_valid exactly 5 edges after accept.
- m=0, s=1001, a=0xFFFF, b=0x0001, c_in=0 -> f=0x0000, c_out=1, zero=1. With ULA_OVF_EN, a=0x7FFF, b=0x0001 -> f=0x8000, ovf=1.
- m=0, s=0110, a=0x1234, b=0x1234, c_in=1 -> f=0x0000, c_out=1, a_eq_b=1, zero=1.
- m=1, s=0110, a=0xF0F0, b=0xFF00, c_in=1 -> f=0x0FF0, c_out=0. Changing a and b during RUN does not alter the result.
- out_ready held 0 for 10 cycles in DONE -> f and flags stable, in_ready=0, a second in_valid is not accepted. Then out_ready=1 -> IDLE and the second op is accepted.
- rst_n pulsed low asynchronously at RUN k=2 -> all outputs 0 immediately, in_ready=1 after release, the next op completes correctly.

Source files
------------

// File: rtl/ula_nibble_seq.sv
// Nibble-serial ALU: one 4-bit function slice reused for WIDTH/4 cycles, LSB nibble first,
// with the carry chained between cycles. Optional ULA_OVF_EN adds a two's-complement ovf output.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation request
// RUN   | processing nibble k with the chained carry, one nibble per clock
// DONE  | result and flags held with out_valid high until out_ready
module ula_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             zero
`ifdef ULA_OVF_EN
  , output logic           ovf
`endif
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, f_q, f_nxt;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q, carry_nxt;
  logic [KW-1:0]    k_q;
  logic             c_out_q, a_eq_b_q, zero_q;
  logic             accept, last_nib;

  logic [WIDTH-1:0] a_sh, b_sh, nib_mask, res_wide;
  logic [3:0]       a_nib, b_nib, x_nib, y_nib, l_res, res_nib;
  logic [4:0]       sum5;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_nib = (state_q == RUN) && (k_q == KW'(N - 1));

  // nibble select by shifting so N need not be a power of two
  assign a_sh  = a_q >> {k_q, 2'b00};
  assign b_sh  = b_q >> {k_q, 2'b00};
  assign a_nib = a_sh[3:0];
  assign b_nib = b_sh[3:0];

  always_comb begin
    l_res = 4'h0;
    case (s_q)
      4'h0: l_res = ~a_nib;
      4'h1: l_res = ~(a_nib | b_nib);
      4'h2: l_res = ~a_nib & b_nib;
      4'h3: l_res = 4'h0;
      4'h4: l_res = ~(a_nib & b_nib);
      4'h5: l_res = ~b_nib;
      4'h6: l_res = a_nib ^ b_nib;
      4'h7: l_res = a_nib & ~b_nib;
      4'h8: l_res = a_nib & b_nib;
      4'h9: l_res = ~(a_nib ^ b_nib);
      4'hA: l_res = b_nib;
      4'hB: l_res = ~a_nib | b_nib;
      4'hC: l_res = 4'hF;
      4'hD: l_res = a_nib | ~b_nib;
      4'hE: l_res = a_nib | b_nib;
      4'hF: l_res = a_nib;
      default: l_res = 4'h0;
    endcase
  end

  always_comb begin
    x_nib = a_nib;
    y_nib = 4'h0;
    case (s_q)
      4'h0: begin x_nib = a_nib;           y_nib = 4'h0;            end
      4'h1: begin x_nib = a_nib | b_nib;   y_nib = 4'h0;            end
      4'h2: begin x_nib = a_nib | ~b_nib;  y_nib = 4'h0;            end
      4'h3: begin x_nib = 4'h0;            y_nib = 4'hF;            end
      4'h4: begin x_nib = a_nib;           y_nib = a_nib & ~b_nib;  end
      4'h5: begin x_nib = a_nib | b_nib;   y_nib = a_nib & ~b_nib;  end
      4'h6: begin x_nib = a_nib;           y_nib = ~b_nib;          end
      4'h7: begin x_nib = a_nib & ~b_nib;  y_nib = 4'hF;            end
      4'h8: begin x_nib = a_nib;           y_nib = a_nib & b_nib;   end
      4'h9: begin x_nib = a_nib;           y_nib = b_nib;           end
      4'hA: begin x_nib = a_nib | ~b_nib;  y_nib = a_nib & b_nib;   end
      4'hB: begin x_nib = a_nib & b_nib;   y_nib = 4'hF;            end
      4'hC: begin x_nib = a_nib;           y_nib = a_nib;           end
      4'hD: begin x_nib = a_nib | b_nib;   y_nib = a_nib;           end
      4'hE: begin x_nib = a_nib | ~b_nib;  y_nib = a_nib;           end
      4'hF: begin x_nib = a_nib;           y_nib = 4'hF;            end
      default: begin x_nib = a_nib;        y_nib = 4'h0;            end
    endcase
  end

  assign sum5      = {1'b0, x_nib} + {1'b0, y_nib} + {4'b0000, carry_q};
  assign res_nib   = m_q ? l_res : sum5[3:0];
  assign carry_nxt = m_q ? 1'b0 : sum5[4];

  assign nib_mask = WIDTH'(4'hF) << {k_q, 2'b00};
  assign res_wide = WIDTH'(res_nib) << {k_q, 2'b00};
  assign f_nxt    = (f_q & ~nib_mask) | res_wide;

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= 4'h0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      f_q      <= '0;
      c_out_q  <= 1'b0;
      a_eq_b_q <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      s_q     <= s;
      m_q     <= m;
      carry_q <= c_in;
      k_q     <= '0;
    end else if (state_q == RUN) begin
      f_q     <= f_nxt;
      carry_q <= carry_nxt;
      k_q     <= last_nib ? '0 : k_q + 1'b1;
      if (last_nib) begin
        c_out_q  <= carry_nxt;
        a_eq_b_q <= (a_q == b_q);
        zero_q   <= (f_nxt == '0);
      end
    end
  end

`ifdef ULA_OVF_EN
  logic ovf_q;

  // only the top nibble's MSBs of X, Y and the sum decide signed overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (last_nib)
      ovf_q <= !m_q && (x_nib[3] == y_nib[3]) && (sum5[3] != x_nib[3]);
  end

  assign ovf = ovf_q;
`endif

  assign f      = f_q;
  assign c_out  = c_out_q;
  assign a_eq_b = a_eq_b_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Directed bench for ula_nibble_seq (WIDTH=16): latency, function table samples,
// DONE hold-off, async reset mid-operation and back-to-back throughput.
module tb_ula_nibble_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   s = 4'h0;
  logic         m = 1'b0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] f;
  logic         c_out;
  logic         a_eq_b;
  logic         zero;
`ifdef ULA_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  ula_nibble_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .m         (m),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .c_out     (c_out),
    .a_eq_b    (a_eq_b),
    .zero      (zero)
`ifdef ULA_OVF_EN
    , .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Issues one op from IDLE; edges counts the accept edge as edge 1.
  // scramble changes the inputs right after the accept edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [3:0] ts,
                        input logic tm, input logic tc, input bit scramble,
                        output int edges, output bit tout);
    a = ta; b = tb_v; s = ts; m = tm; c_in = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (scramble) begin
      a = ~ta; b = 16'h1357; s = ~ts; m = ~tm; c_in = ~tc;
    end
    edges = 1;
    tout  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        tout = 1'b0;
        break;
      end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (f !== 16'h0000) begin bad++; $display("FAIL reset_f got=%h exp=0000", f); end
    total++; if ({c_out, a_eq_b, zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {c_out, a_eq_b, zero}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_latency();
    int e; bit t;
    run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0, e, t);
    total++; if (t) begin bad++; $display("FAIL add_timeout got=timeout exp=out_valid"); end
    total++; if (e !== 5) begin bad++; $display("FAIL add_latency got=%0d exp=5", e); end
    total++; if (f !== 16'h0100) begin bad++; $display("FAIL add_f got=%h exp=0100", f); end
    total++; if ({c_out, zero, a_eq_b} !== 3'b000) begin bad++; $display("FAIL add_flags got=%b exp=000", {c_out, zero, a_eq_b}); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add_in_ready_done got=%b exp=0", in_ready); end
    release_out();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_out_valid_drop got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_back_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_carry_wrap();
    int e; bit t;
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0, e, t);
    total++; if (t) begin bad++; $display("FAIL wrap_timeout got=timeout exp=out_valid"); end
    total++; if (f !== 16'h0000) begin bad++; $display("FAIL wrap_f got=%h exp=0000", f); end
    total++; if ({c_out, zero} !== 2'b11) begin bad++; $display("FAIL wrap_flags got=%b exp=11", {c_out, zero}); end
`ifdef ULA_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b exp=0", ovf); end
`endif
    release_out();
`ifdef ULA_OVF_EN
    run_op(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0, e, t);
    total++; if (f !== 16'h8000) begin bad++; $display("FAIL ovf_f got=%h exp=8000", f); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    release_out();
`endif
  endtask

  task automatic test_sub_equal();
    int e; bit t;
    run_op(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 1'b0, e, t);
    total++; if (t) begin bad++; $display("FAIL sub_timeout got=timeout exp=out_valid"); end
    total++; if (f !== 16'h0000) begin bad++; $display("FAIL sub_f got=%h exp=0000", f); end
    total++; if ({c_out, a_eq_b, zero} !== 3'b111) begin bad++; $display("FAIL sub_flags got=%b exp=111", {c_out, a_eq_b, zero}); end
    release_out();
  endtask

  task automatic test_logic_inputs_ignored();
    int e; bit t;
    run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b1, e, t);
    total++; if (t) begin bad++; $display("FAIL xor_timeout got=timeout exp=out_valid"); end
    total++; if (f !== 16'h0FF0) begin bad++; $display("FAIL xor_f got=%h exp=0ff0", f); end
    total++; if ({c_out, zero, a_eq_b} !== 3'b000) begin bad++; $display("FAIL xor_flags got=%b exp=000", {c_out, zero, a_eq_b}); end
    release_out();
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [9] = '{16'h1234, 16'h1234, 16'hFFFF, 16'h1234, 16'h8001, 16'h0005, 16'h0000, 16'h00F0, 16'hF0F0};
    logic [W-1:0] vb [9] = '{16'h5678, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0030, 16'hFF00};
    logic [3:0]   vs [9] = '{4'hC, 4'h3, 4'h0, 4'h0, 4'hC, 4'h6, 4'hF, 4'h4, 4'hB};
    logic         vm [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         vc [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] ef [9] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hEDCB, 16'h0002, 16'h0002, 16'hFFFF, 16'h01B0, 16'hFF0F};
    logic         ec [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int e; bit t;
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], vs[i], vm[i], vc[i], 1'b0, e, t);
      total++; if (t || f !== ef[i]) begin bad++; $display("FAIL vec%0d_f got=%h exp=%h timeout=%0d", i, f, ef[i], t); end
      total++; if (c_out !== ec[i]) begin bad++; $display("FAIL vec%0d_c_out got=%b exp=%b", i, c_out, ec[i]); end
      release_out();
    end
  endtask

  task automatic test_done_hold();
    int e; bit t;
    int cnt;
    run_op(16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b0, 1'b0, e, t);
    a = 16'h0010; b = 16'h0020; s = 4'b1001; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 && f === 16'h0007 && in_ready === 1'b0 && c_out === 1'b0) cnt++;
    end
    total++; if (cnt !== 10) begin bad++; $display("FAIL hold_stable got=%0d exp=10 cycles", cnt); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL hold_release got=%b exp=01", {out_valid, in_ready}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_second_accept got=%b exp=0", in_ready); end
    t = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin t = 1'b0; break; end
      @(posedge clk); #1;
    end
    total++; if (t || f !== 16'h0030) begin bad++; $display("FAIL hold_second_f got=%h exp=0030 timeout=%0d", f, t); end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    int e; bit t;
    a = 16'h1111; b = 16'h1111; s = 4'b1001; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (f !== 16'h0022) begin bad++; $display("FAIL rst_partial_f got=%h exp=0022", f); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({out_valid, c_out, a_eq_b, zero} !== 4'b0000 || f !== 16'h0000) begin
      bad++; $display("FAIL rst_mid_outputs got=%b/%h exp=0000/0000", {out_valid, c_out, a_eq_b, zero}, f);
    end
    #2 rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0, e, t);
    total++; if (t || e !== 5 || f !== 16'h0100) begin bad++; $display("FAIL rst_next_op got=%h/%0d exp=0100/5", f, e); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int pulses, overlap, good_f;
    a = 16'h1000; b = 16'h0234; s = 4'b1001; m = 1'b0; c_in = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    pulses = 0; overlap = 0; good_f = 0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        pulses++;
        if (f === 16'h1234) good_f++;
      end
      if (out_valid && in_ready) overlap++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_results got=%0d exp=3", pulses); end
    total++; if (good_f !== 3) begin bad++; $display("FAIL b2b_f_ok got=%0d exp=3", good_f); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_ready_overlap got=%0d exp=0", overlap); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_carry_wrap();
    test_sub_equal();
    test_logic_inputs_ignored();
    test_vectors();
    test_done_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
